// File: rtl/channel_deinterleaver_pkg.sv
// Shared dataflow constants for the channel interleaver/deinterleaver pair,
// so both ends agree on group size and channel ordering.
package channel_deinterleaver_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int NUM_CHANNELS       = 4;
    localparam int CH_IDX_W           = $clog2(NUM_CHANNELS);

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    localparam ch_idx_t FIRST_CH = '0;
    localparam ch_idx_t LAST_CH  = ch_idx_t'(NUM_CHANNELS - 1);

    // Slot that follows idx in the ch0..ch3 rotation.
    function automatic ch_idx_t next_ch(input ch_idx_t idx);
        return (idx == LAST_CH) ? FIRST_CH : ch_idx_t'(idx + ch_idx_t'(1));
    endfunction

endpackage

// File: rtl/channel_deinterleaver_if.sv
// Serialized input stream and parallel group output of the deinterleaver.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the sender holds its payload stable until that edge.
interface channel_deinterleaver_if #(
    parameter int DATA_WIDTH = channel_deinterleaver_pkg::DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_first;
    logic                  in_valid;
    logic                  in_ready;

    logic [DATA_WIDTH-1:0] out_ch0;
    logic [DATA_WIDTH-1:0] out_ch1;
    logic [DATA_WIDTH-1:0] out_ch2;
    logic [DATA_WIDTH-1:0] out_ch3;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_desync;

    modport master (
        output in_data, in_first, in_valid, out_ready,
        input  in_ready, out_ch0, out_ch1, out_ch2, out_ch3, out_valid, out_desync
    );

    modport slave (
        input  in_data, in_first, in_valid, out_ready,
        output in_ready, out_ch0, out_ch1, out_ch2, out_ch3, out_valid, out_desync
    );

endinterface

// File: rtl/channel_deinterleaver.sv
// Reassembles a ch0..ch3 serialized word stream into parallel channel groups,
// using a collection register plus an output holding register as a double buffer.
module channel_deinterleaver
    import channel_deinterleaver_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    channel_deinterleaver_if.slave  bus
);

    logic [DATA_WIDTH-1:0] col [NUM_CHANNELS-1];
    ch_idx_t               idx;

    logic [DATA_WIDTH-1:0] out_ch0_q;
    logic [DATA_WIDTH-1:0] out_ch1_q;
    logic [DATA_WIDTH-1:0] out_ch2_q;
    logic [DATA_WIDTH-1:0] out_ch3_q;
    logic                  out_valid_q;
    logic                  out_desync_q;

    logic accept_in;
    logic drain_out;
    logic realign;
    logic complete;
    logic in_ready_c;

    // Only the group-completing word can stall: it needs the holding register,
    // which must be empty or emptying this very cycle.
    assign in_ready_c = (idx != LAST_CH) || !out_valid_q || bus.out_ready;
    assign accept_in  = bus.in_valid && in_ready_c;
    assign drain_out  = out_valid_q && bus.out_ready;
    assign realign    = accept_in && bus.in_first && (idx != FIRST_CH);
    assign complete   = accept_in && !realign && (idx == LAST_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
                col[i] <= '0;
            end
            idx          <= FIRST_CH;
            out_ch0_q    <= '0;
            out_ch1_q    <= '0;
            out_ch2_q    <= '0;
            out_ch3_q    <= '0;
            out_valid_q  <= 1'b0;
            out_desync_q <= 1'b0;
        end else begin
            out_desync_q <= realign;

            if (drain_out) begin
                out_valid_q <= 1'b0;
            end

            if (realign) begin
                // A mid-group marker restarts collection; the partial group is dropped.
                col[0] <= bus.in_data;
                idx    <= ch_idx_t'(1);
            end else if (complete) begin
                out_ch0_q   <= col[0];
                out_ch1_q   <= col[1];
                out_ch2_q   <= col[2];
                out_ch3_q   <= bus.in_data;
                out_valid_q <= 1'b1;
                idx         <= FIRST_CH;
            end else if (accept_in) begin
                for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
                    if (idx == ch_idx_t'(i)) begin
                        col[i] <= bus.in_data;
                    end
                end
                idx <= next_ch(idx);
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_ch0    = out_ch0_q;
    assign bus.out_ch1    = out_ch1_q;
    assign bus.out_ch2    = out_ch2_q;
    assign bus.out_ch3    = out_ch3_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_desync = out_desync_q;

endmodule

// File: tb/tb_channel_deinterleaver.sv
// Directed bench for channel_deinterleaver: hand-computed groups, stalls,
// realignment, mid-stream reset and a gapped stream checked against a queue.
module tb_channel_deinterleaver;
    import channel_deinterleaver_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [4*W-1:0] exp_q [$];

    channel_deinterleaver_if #(.DATA_WIDTH(W)) bus ();

    channel_deinterleaver #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic first, input logic v);
        bus.in_data  = d;
        bus.in_first = first;
        bus.in_valid = v;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_group(input string tag, input logic [4*W-1:0] exp);
        check(tag, {bus.out_ch0, bus.out_ch1, bus.out_ch2, bus.out_ch3}, exp);
    endtask

    initial begin
        int cyc;
        int words_sent;
        int groups_seen;
        logic acc_in;
        logic acc_out;
        logic [W-1:0] w;
        logic [4*W-1:0] grp;
        logic [4*W-1:0] held;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (2) tick();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_desync", bus.out_desync, 0);
        check_group("reset_out_ch", '0);
        check("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // single group 1,2,3,4
        for (int i = 1; i <= 4; i++) begin
            drive(W'(i), i == 1, 1'b1);
            tick();
            if (i < 4) check("single_no_early_valid", bus.out_valid, 0);
        end
        drive('0, 1'b0, 1'b0);
        check("single_valid", bus.out_valid, 1);
        check_group("single_group", {16'h0001, 16'h0002, 16'h0003, 16'h0004});
        tick();
        check("single_valid_one_cycle", bus.out_valid, 0);

        // continuous 16 words 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            drive(W'(16'h10 + i), (i % 4) == 0, 1'b1);
            check("stream_in_ready", bus.in_ready, 1);
            tick();
            check("stream_valid", bus.out_valid, (i % 4) == 3);
            if ((i % 4) == 3) begin
                w = W'(16'h10 + i - 3);
                check_group("stream_group", {w, W'(w + 1), W'(w + 2), W'(w + 3)});
            end
        end
        drive('0, 1'b0, 1'b0);
        tick();

        // backpressure: 8 words with out_ready low
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(W'(16'h20 + i), i == 0, 1'b1);
            tick();
        end
        check("stall_group1_valid", bus.out_valid, 1);
        check_group("stall_group1", {16'h0020, 16'h0021, 16'h0022, 16'h0023});
        for (int i = 4; i < 7; i++) begin
            drive(W'(16'h20 + i), i == 4, 1'b1);
            check("stall_accept_5to7", bus.in_ready, 1);
            tick();
            check_group("stall_group1_held", {16'h0020, 16'h0021, 16'h0022, 16'h0023});
        end
        drive(16'h0027, 1'b0, 1'b1);
        check("stall_in_ready_low", bus.in_ready, 0);
        tick();
        check("stall_still_valid", bus.out_valid, 1);
        check_group("stall_still_held", {16'h0020, 16'h0021, 16'h0022, 16'h0023});
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        tick();
        drive('0, 1'b0, 1'b0);
        check("release_group2_valid", bus.out_valid, 1);
        check_group("release_group2", {16'h0024, 16'h0025, 16'h0026, 16'h0027});
        tick();
        check("release_drained", bus.out_valid, 0);

        // realignment: A0 A1 then B0 with marker
        drive(16'h00A0, 1'b1, 1'b1); tick();
        drive(16'h00A1, 1'b0, 1'b1); tick();
        check("desync_quiet_before", bus.out_desync, 0);
        drive(16'h00B0, 1'b1, 1'b1); tick();
        check("desync_pulse", bus.out_desync, 1);
        check("desync_no_output", bus.out_valid, 0);
        drive(16'h00B1, 1'b0, 1'b1); tick();
        check("desync_pulse_ends", bus.out_desync, 0);
        drive(16'h00B2, 1'b0, 1'b1); tick();
        drive(16'h00B3, 1'b0, 1'b1); tick();
        drive('0, 1'b0, 1'b0);
        check("desync_group_valid", bus.out_valid, 1);
        check_group("desync_group", {16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3});
        check("desync_once", bus.out_desync, 0);
        tick();

        // reset after 2 words
        drive(16'h00C0, 1'b1, 1'b1); tick();
        drive(16'h00C1, 1'b0, 1'b1); tick();
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check_group("rst_mid_ch", '0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        // reset while holding a group
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(W'(16'h00D0 + i), i == 0, 1'b1);
            tick();
        end
        drive('0, 1'b0, 1'b0);
        check_group("rst_hold_group", {16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3});
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", bus.out_valid, 0);
        check_group("rst_hold_ch", '0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(W'(16'h00E0 + i), 1'b0, 1'b1);
            tick();
            if (i < 3) check("rst_post_no_early", bus.out_valid, 0);
        end
        drive('0, 1'b0, 1'b0);
        check("rst_post_valid", bus.out_valid, 1);
        check_group("rst_post_group", {16'h00E0, 16'h00E1, 16'h00E2, 16'h00E3});
        tick();

        // gapped stream, 8 groups, scoreboard
        words_sent  = 0;
        groups_seen = 0;
        held        = '0;
        cyc         = 0;
        grp         = '0;
        while (groups_seen < 8 && cyc < 2000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            w = W'(16'h0300 + words_sent * 37);
            if (words_sent < 32 && $urandom_range(0, 2) != 0)
                drive(w, (words_sent % 4) == 0, 1'b1);
            else
                drive(w, 1'b0, 1'b0);
            acc_in  = bus.in_valid && bus.in_ready;
            acc_out = bus.out_valid && bus.out_ready;
            if (bus.out_valid && !bus.out_ready && held != '0)
                check_group("gap_held_stable", held);
            if (acc_out) begin
                if (exp_q.size() == 0) begin
                    check("gap_unexpected_group", 1, 0);
                end else begin
                    check_group("gap_group", exp_q.pop_front());
                end
                groups_seen++;
            end
            held = (bus.out_valid && !bus.out_ready)
                   ? {bus.out_ch0, bus.out_ch1, bus.out_ch2, bus.out_ch3} : '0;
            tick();
            check("gap_no_desync", bus.out_desync, 0);
            if (acc_in) begin
                grp = {grp[3*W-1:0], w};
                if ((words_sent % 4) == 3) exp_q.push_back(grp);
                words_sent++;
            end
            cyc++;
        end
        check("gap_all_groups", groups_seen, 8);
        check("gap_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
